uart_tx_sched: RTL and testbench

- Round-robin scheduler sharing one UART transmit line among N_REQ byte producers.
- Arbitrates pending requests, accepts one byte per frame over a valid/ready handshake, and sequences the frame bit-by-bit with an internal baud divider.
- Frame format: start(0), 8 data bits LSB first, even parity (1 when the data has an odd count of ones), stop(1).
- Sits between the on-chip producers and the serial pin.

---
 rtl/uart_tx_sched.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter feeding one UART transmitter.
// Frame: start(0), 8 data bits LSB first, even parity, stop(1).
// Optional build macro UART_TX_STOP2_EN: two stop bits instead of one.
module uart_tx_sched #(
   parameter  int N_REQ        = 4,
   parameter  int CLKS_PER_BIT = 16,
   localparam int ID_W         = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 tx,
   output logic                 busy,
   output logic [ID_W-1:0]      grant_id,
   output logic                 frame_done
);

   localparam int unsigned       NR        = N_REQ;
   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  baud_q,  baud_d;
   logic [2:0]        bit_q,   bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_q,   par_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_q,  last_d;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ID_W-1:0]   cand;
   logic              baud_end;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NR; k++) begin
         cand = ID_W'((32'(last_q) + k) % NR);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Grant strobe only in IDLE and never while reset is held
   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && rst && win_found) begin
         req_ready = N_REQ'(1) << win_idx;
      end
   end

   assign baud_end = (baud_q == BAUD_LAST);
   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;

   // Serial line level is a pure function of the registered state
   always_comb begin
      tx = 1'b1;
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shift_q[0];
         PARITY:  tx = par_q;
         default: tx = 1'b1;
      endcase
   end

   // Frame sequencing: next-state, counters, shift register and done pulse
   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      grant_d    = grant_q;
      last_d     = last_q;
      frame_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_ready != '0) begin
               shift_d = req_data[8*win_idx +: 8];
               grant_d = win_idx;
               last_d  = win_idx;
               par_d   = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               state_d = START;
            end
         end

         START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               par_d   = par_q ^ shift_q[0];
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = PARITY;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         PARITY: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         STOP: begin
            if (baud_end) begin
               baud_d = '0;
`ifdef UART_TX_STOP2_EN
               // bit counter is idle here, so it marks first vs second stop bit
               if (bit_q == 3'd0) begin
                  bit_d = 3'd1;
               end else begin
                  bit_d      = '0;
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
`else
               frame_done = 1'b1;
               state_d    = IDLE;
`endif
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset idles the line and gives requester 0 first priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         grant_q <= '0;
         last_q  <= ID_W'(N_REQ - 1);
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with N_REQ=4, CLKS_PER_BIT=4.
// Honours UART_TX_STOP2_EN for the expected frame length.
module tb_uart_tx_sched;

   localparam int N   = 4;
   localparam int CPB = 4;
`ifdef UART_TX_STOP2_EN
   localparam int NBITS = 12;
`else
   localparam int NBITS = 11;
`endif
   localparam int FRAME = NBITS * CPB;

   // Expected line bits, index 0 = start ... 9 = parity, 10/11 = stop
   localparam logic [11:0] F_A5 = 12'b1_1_0_1010_0101_0;
   localparam logic [11:0] F_07 = 12'b1_1_1_0000_0111_0;
   localparam logic [11:0] F_00 = 12'b1_1_0_0000_0000_0;
   localparam logic [11:0] F_11 = 12'b1_1_0_0001_0001_0;
   localparam logic [11:0] F_80 = 12'b1_1_1_1000_0000_0;
   localparam logic [11:0] F_FF = 12'b1_1_0_1111_1111_0;
   localparam logic [11:0] F_3C = 12'b1_1_0_0011_1100_0;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           tx;
   logic           busy;
   logic [1:0]     grant_id;
   logic           frame_done;

   int n_checks;
   int n_fail;

   uart_tx_sched #(
      .N_REQ        (N),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .tx         (tx),
      .busy       (busy),
      .grant_id   (grant_id),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called on a negedge while IDLE; requester id must win at the next posedge
   task automatic run_frame(input int id, input logic [11:0] bits, input bit drop, input string tag);
      check({tag, " ready"}, 32'(req_ready), 32'(1) << id);
      @(posedge clk);
      @(negedge clk);
      if (drop) req_valid[id] = 1'b0;
      check({tag, " grant_id"}, 32'(grant_id), 32'(id));
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " ready low"}, 32'(req_ready), 32'd0);
      for (int c = 1; c <= FRAME; c++) begin
         if (c > 1) @(negedge clk);
         check({tag, " tx"}, 32'(tx), 32'(bits[(c-1)/CPB]));
         check({tag, " frame_done"}, 32'(frame_done), 32'(c == FRAME));
      end
      @(negedge clk);
      check({tag, " idle tx"}, 32'(tx), 32'd1);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " idle done"}, 32'(frame_done), 32'd0);
      check({tag, " grant hold"}, 32'(grant_id), 32'(id));
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      req_valid = N'($urandom);
      req_data  = $urandom;

      // Reset holds outputs quiet regardless of requests
      #1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = N'($urandom);
         #1;
         check("reset outs", 32'({tx, busy, req_ready, grant_id, frame_done}), 32'b1_0_0000_00_0);
      end

      @(negedge clk);
      req_valid = '0;
      req_data  = '0;
      rst       = 1'b1;
      @(negedge clk);
      check("idle no req", 32'(req_ready), 32'd0);

      // Single frame: requester 2, 0xA5
      req_data[8*2 +: 8] = 8'hA5;
      req_valid = 4'b0100;
      #1;
      run_frame(2, F_A5, 1'b1, "single");

      // Parity cases on requester 0
      req_data[8*0 +: 8] = 8'h07;
      req_valid = 4'b0001;
      #1;
      run_frame(0, F_07, 1'b1, "par07");
      req_data[8*0 +: 8] = 8'h00;
      req_valid = 4'b0001;
      #1;
      run_frame(0, F_00, 1'b1, "par00");

      // Round robin from requester 1 onward after last grant 0 -> restart from reset
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req_data  = {8'h3C, 8'hFF, 8'h80, 8'h11};
      req_valid = 4'b1111;
      #1;
      run_frame(0, F_11, 1'b1, "rr0");
      run_frame(1, F_80, 1'b1, "rr1");
      run_frame(2, F_FF, 1'b1, "rr2");
      run_frame(3, F_3C, 1'b1, "rr3");

      // Two persistent requesters alternate
      req_valid = 4'b1010;
      #1;
      run_frame(1, F_80, 1'b0, "alt1a");
      run_frame(3, F_3C, 1'b0, "alt3a");
      run_frame(1, F_80, 1'b0, "alt1b");
      run_frame(3, F_3C, 1'b0, "alt3b");
      req_valid = '0;
      #1;
      check("alt cleared", 32'(req_ready), 32'd0);

      // Reset mid-frame during data bit 3 (cycles 17..20 after acceptance)
      @(negedge clk);
      req_data[8*2 +: 8] = 8'hA5;
      req_valid = 4'b0100;
      #1;
      check("mid ready", 32'(req_ready), 32'b0100);
      @(posedge clk);
      @(negedge clk);
      repeat (17) @(negedge clk);
      check("mid tx before", 32'(tx), 32'd0);
      rst = 1'b0;
      req_data[8*0 +: 8] = 8'h11;
      req_valid = 4'b0101;
      #1;
      check("mid reset outs", 32'({tx, busy, req_ready, frame_done}), 32'b1_0_0000_0);
      repeat (3) @(negedge clk);
      check("mid reset hold", 32'(req_ready), 32'd0);
      rst = 1'b1;
      #1;
      run_frame(0, F_11, 1'b1, "post");
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
